// File: rtl/regfile_wr_sched_if.sv
// Write-request and register-file port bundle for regfile_wr_sched.
// The master side drives the requests; the slave side is the scheduler.
interface regfile_wr_sched_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] waddr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               clrall;
    logic               clrall_busy;
    logic               clrall_done;
    logic [DW-1:0]      rf_data;
    logic [AW-1:0]      rf_regen;
    logic [AW-1:0]      rf_regclr;
    logic               rf_rfe;

    modport master (
        output req, waddr, wdata, clrall,
        input  gnt, clrall_busy, clrall_done, rf_data, rf_regen, rf_regclr, rf_rfe
    );

    modport slave (
        input  req, waddr, wdata, clrall,
        output gnt, clrall_busy, clrall_done, rf_data, rf_regen, rf_regclr, rf_rfe
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for a 16x32 register file: one grant per cycle plus a clear-all sweep.
// Define RF_SCHED_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module regfile_wr_sched #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    regfile_wr_sched_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StWrite, StSweep} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            rfe_q, rfe_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   regen_q, regen_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [IW-1:0]   win;

`ifdef RF_SCHED_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW:0]     cand;

    // Search starts at the pointer and wraps modulo NREQ.
    always_comb begin
        elig  = bus.req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            cand = {1'b0, ptr_q} + (IW + 1)'(o);
            if (cand >= (IW + 1)'(NREQ)) begin
                cand = cand - (IW + 1)'(NREQ);
            end
            if (!found && elig[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end
`else
    always_comb begin
        elig  = bus.req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        rfe_d   = 1'b1;
        data_d  = data_q;
        regen_d = regen_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef RF_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StSweep: begin
                data_d = '0;
                if (idx_q == '1) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    rfe_d   = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    regen_d = idx_q + 1'b1;
                end
            end
            StIdle, StWrite: begin
                if (bus.clrall) begin
                    // Clear-all beats any pending request; requests simply wait.
                    state_d = StSweep;
                    rfe_d   = 1'b0;
                    busy_d  = 1'b1;
                    data_d  = '0;
                    regen_d = '0;
                    idx_d   = '0;
                end else if (found) begin
                    state_d    = StWrite;
                    gnt_d[win] = 1'b1;
                    rfe_d      = 1'b0;
                    regen_d    = bus.waddr[win*AW +: AW];
                    data_d     = bus.wdata[win*DW +: DW];
`ifdef RF_SCHED_RR_EN
                    ptr_d      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            rfe_q   <= 1'b1;
            data_q  <= '0;
            regen_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rfe_q   <= rfe_d;
            data_q  <= data_d;
            regen_q <= regen_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef RF_SCHED_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Clear select mirrors enable so the shared RFE only ever touches the target register.
    assign bus.gnt         = gnt_q;
    assign bus.rf_rfe      = rfe_q;
    assign bus.rf_data     = data_q;
    assign bus.rf_regen    = regen_q;
    assign bus.rf_regclr   = regen_q;
    assign bus.clrall_busy = busy_q;
    assign bus.clrall_done = done_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against a cycle-level behavioural model and a register-file model.
module tb_regfile_wr_sched;
    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_wr_sched_if #(.NREQ(NREQ), .DW(32), .AW(4)) bus ();

    regfile_wr_sched #(.NREQ(NREQ), .DW(32), .AW(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register file as seen by the scheduler: captures the port on the edge after it is driven.
    logic [31:0] rf [16];
    always @(posedge clk) begin
        if (rst_n && !bus.rf_rfe && bus.rf_regclr == bus.rf_regen) rf[bus.rf_regen] <= bus.rf_data;
    end

    // Behavioural model: m_k is the sweep index shown (-1 when not sweeping).
    logic [NREQ-1:0] e_gnt;
    logic            e_rfe, e_busy, e_done;
    logic [31:0]     e_data;
    logic [3:0]      e_regen;
    int              m_k, m_ptr, m_w;
    logic [NREQ-1:0] m_elig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_gnt = '0; e_rfe = 1'b1; e_data = '0; e_regen = '0; e_busy = 1'b0; e_done = 1'b0;
            m_k = -1; m_ptr = 0;
        end else begin
            e_done = 1'b0;
            if (m_k >= 0) begin
                e_gnt = '0; e_data = '0;
                if (m_k == 15) begin
                    m_k = -1; e_done = 1'b1; e_busy = 1'b0; e_rfe = 1'b1;
                end else begin
                    m_k++; e_regen = 4'(m_k); e_rfe = 1'b0; e_busy = 1'b1;
                end
            end else if (bus.clrall) begin
                m_k = 0; e_gnt = '0; e_rfe = 1'b0; e_data = '0; e_regen = '0; e_busy = 1'b1;
            end else begin
                m_elig = bus.req & ~e_gnt;
                m_w = -1;
                for (int o = 0; o < NREQ; o++) begin
                    if (m_w < 0 && m_elig[(m_ptr + o) % NREQ]) m_w = (m_ptr + o) % NREQ;
                end
                e_gnt = '0;
                if (m_w >= 0) begin
                    e_gnt[m_w] = 1'b1;
                    e_rfe = 1'b0;
                    e_regen = bus.waddr[m_w*4 +: 4];
                    e_data = bus.wdata[m_w*32 +: 32];
`ifdef RF_SCHED_RR_EN
                    m_ptr = (m_w + 1) % NREQ;
`endif
                end else begin
                    e_rfe = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("m_gnt", 32'(bus.gnt), 32'(e_gnt));
            cmp("m_rfe", 32'(bus.rf_rfe), 32'(e_rfe));
            cmp("m_data", bus.rf_data, e_data);
            cmp("m_regen", 32'(bus.rf_regen), 32'(e_regen));
            cmp("m_regclr", 32'(bus.rf_regclr), 32'(e_regen));
            cmp("m_busy", 32'(bus.clrall_busy), 32'(e_busy));
            cmp("m_done", 32'(bus.clrall_done), 32'(e_done));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [NREQ-1:0] exp_seq [4];
    bit seen;

    initial begin
        bus.req = '0; bus.waddr = '0; bus.wdata = '0; bus.clrall = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cmp("rst_rfe", 32'(bus.rf_rfe), 32'd1);
        cmp("rst_gnt", 32'(bus.gnt), 32'd0);
        cmp("rst_regen", 32'(bus.rf_regen), 32'd0);

        // Single write from requester 1.
        bus.req = 3'b010; bus.waddr[7:4] = 4'd5; bus.wdata[63:32] = 32'hDEADBEEF;
        tick();
        cmp("single_gnt", 32'(bus.gnt), 32'b010);
        cmp("single_regen", 32'(bus.rf_regen), 32'd5);
        cmp("single_rfe", 32'(bus.rf_rfe), 32'd0);
        cmp("single_data", bus.rf_data, 32'hDEADBEEF);
        bus.req = '0;
        tick();
        cmp("single_reg5", rf[5], 32'hDEADBEEF);

        // One requester held alone is granted on alternate cycles.
        do_reset();
        bus.req = 3'b001;
        for (int c = 0; c < 4; c++) begin
            tick();
            cmp("hold_gnt", 32'(bus.gnt), (c % 2 == 0) ? 32'd1 : 32'd0);
            cmp("hold_rfe", 32'(bus.rf_rfe), (c % 2 == 0) ? 32'd0 : 32'd1);
        end
        bus.req = '0;
        tick();

        // All three held.
        do_reset();
`ifdef RF_SCHED_RR_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
        bus.req = 3'b111;
        for (int c = 0; c < 4; c++) begin
            tick();
            cmp("contend_gnt", 32'(bus.gnt), 32'(exp_seq[c]));
        end
        bus.req = '0;
        tick();

        // Preload every register, then sweep.
        for (int j = 0; j < 16; j++) begin
            bus.req = 3'b001; bus.waddr[3:0] = 4'(j); bus.wdata[31:0] = 32'hFFFFFFFF;
            tick();
            bus.req = '0;
            tick();
        end
        for (int j = 0; j < 16; j++) cmp("preload_reg", rf[j], 32'hFFFFFFFF);
        bus.clrall = 1'b1;
        tick();
        bus.clrall = 1'b0;
        cmp("sweep_busy", 32'(bus.clrall_busy), 32'd1);
        cmp("sweep_k0", 32'(bus.rf_regen), 32'd0);
        cmp("sweep_rfe", 32'(bus.rf_rfe), 32'd0);
        cmp("sweep_data", bus.rf_data, 32'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            cmp("sweep_k", 32'(bus.rf_regen), 32'(k));
        end
        tick();
        cmp("sweep_done", 32'(bus.clrall_done), 32'd1);
        cmp("sweep_busy_end", 32'(bus.clrall_busy), 32'd0);
        cmp("sweep_rfe_end", 32'(bus.rf_rfe), 32'd1);
        tick();
        cmp("sweep_done_pulse", 32'(bus.clrall_done), 32'd0);
        for (int j = 0; j < 16; j++) cmp("swept_reg", rf[j], 32'd0);

        // CLRALL and a request in the same cycle: sweep first.
        do_reset();
        bus.clrall = 1'b1; bus.req = 3'b100; bus.waddr[11:8] = 4'd9;
        tick();
        bus.clrall = 1'b0;
        cmp("coll_gnt0", 32'(bus.gnt), 32'd0);
        cmp("coll_busy", 32'(bus.clrall_busy), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (bus.clrall_done) seen = 1'b1;
            else cmp("coll_no_gnt", 32'(bus.gnt), 32'd0);
        end
        cmp("coll_done_seen", 32'(seen), 32'd1);
        tick();
        cmp("coll_gnt", 32'(bus.gnt), 32'b100);
        cmp("coll_regen", 32'(bus.rf_regen), 32'd9);
        bus.req = '0;
        tick();

        // Reset in the middle of a sweep.
        bus.clrall = 1'b1;
        tick();
        bus.clrall = 1'b0;
        repeat (7) tick();
        cmp("mid_k7", 32'(bus.rf_regen), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        cmp("mid_rst_busy", 32'(bus.clrall_busy), 32'd0);
        cmp("mid_rst_rfe", 32'(bus.rf_rfe), 32'd1);
        cmp("mid_rst_regen", 32'(bus.rf_regen), 32'd0);
        cmp("mid_rst_regclr", 32'(bus.rf_regclr), 32'd0);
        cmp("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        cmp("mid_rst_done", 32'(bus.clrall_done), 32'd0);
        rst_n = 1'b1;
        bus.req = 3'b010; bus.waddr[7:4] = 4'd3;
        tick();
        cmp("post_rst_gnt", 32'(bus.gnt), 32'b010);
        cmp("post_rst_regen", 32'(bus.rf_regen), 32'd3);
        bus.req = '0;
        tick();

        // Random traffic; requesters hold REQ until granted.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i]) begin
                    if (bus.gnt[i] && $urandom_range(0, 9) < 7) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    bus.req[i] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    bus.waddr[i*4 +: 4] = 4'($urandom);
                    bus.wdata[i*32 +: 32] = $urandom;
                end
            end
            bus.clrall = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
